divac: RTL

DIVAC -- requirements
Module: divac

---
 rtl/divac_pkg.sv | 14 +
 rtl/divac_sub4.sv | 19 +
 rtl/divac.sv | 113 +++++++++++
 3 files changed

// File: rtl/divac_pkg.sv
// Shared types and constants for the divac restoring divider.
// Holds the controller state encoding and default sizing used by the top and its bench.
package divac_pkg;

  localparam int DIVAC_WIDTH = 4;
  localparam int DIVAC_CNT_W = $clog2(DIVAC_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divac_sub4.sv
// Combinational trial subtractor for the restoring divider.
// Produces the W-bit difference and a borrow flag that marks a negative result.
module sub4 #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuend_i,
  input  logic [W-1:0] subtrahend_i,
  output logic [W-1:0] diff_o,
  output logic         neg_o
);

  logic [W:0] full;

  // One extra bit catches the borrow out of the W-bit subtraction.
  assign full   = {1'b0, minuend_i} - {1'b0, subtrahend_i};
  assign diff_o = full[W-1:0];
  assign neg_o  = full[W];

endmodule

// File: rtl/divac.sv
// Unsigned restoring divider: one quotient bit per RUN cycle, with a divide-by-zero
// shortcut that reports q = all ones, r = a straight from IDLE.
module divac
  import divac_pkg::*;
#(
  parameter int WIDTH = DIVAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             neg;
  logic             unused_diff_msb;

  assign trial = {rem_q, dvd_q[WIDTH-1]};

  sub4 #(.W(WIDTH + 1)) u_sub4 (
    .minuend_i    (trial),
    .subtrahend_i ({1'b0, dvs_q}),
    .diff_o       (diff),
    .neg_o        (neg)
  );

  // A kept difference is always below the divisor, so its top bit is zero.
  assign unused_diff_msb = diff[WIDTH];

  // NOTE: every next-state signal gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (b != '0) begin
            dvd_d   = a;
            dvs_d   = b;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            dz_d    = 1'b0;
            state_d = RUN;
          end else begin
            quo_d   = '1;
            rem_d   = a;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[WIDTH-2:0], ~neg};
        rem_d = neg ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
    end
  end

  assign q    = quo_q;
  assign r    = rem_q;
  assign dz   = dz_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
